dac_share_arbiter: RTL and testbench

//   Round-robin arbiter sharing the single SPI DAC (start/end-of-conversion handshake) among NREQ

---
 rtl/dac_share_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_dac_share_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_share_arbiter.sv
// dac_share_arbiter
//   Round-robin owner of the single SPI DAC. One requester at a time is
//   granted: its code is latched, a one-cycle start pulse is sent to the DAC
//   driver, end-of-conversion is awaited under an optional watchdog, the owner
//   receives a one-cycle done pulse, and an optional settle gap follows before
//   the next grant is considered.
//
// Ports
//   clk_i        system clock (rising edge)
//   rst_ni       asynchronous active-low reset
//   req_i        per-requester level request, held until its done_o pulse
//   data_i       packed DAC codes, requester k at data_i[k*DW +: DW]
//   gnt_o        one-hot grant, asserted START..DONE inclusive
//   done_o       one-cycle completion pulse to the granted requester
//   timeout_o    one-cycle pulse alongside done_o when the watchdog expired
//   busy_o       high whenever the arbiter is not idle
//   dac_start_o  one-cycle start pulse to the DAC driver
//   dac_data_o   latched code of the granted requester
//   dac_eoc_i    end-of-conversion from the DAC driver (honoured in WAIT only)
module dac_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 12,
    parameter int TIMEOUT = 1024,
    parameter int GAP     = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*DW-1:0]   data_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      done_o,
    output logic                 timeout_o,
    output logic                 busy_o,
    output logic                 dac_start_o,
    output logic [DW-1:0]        dac_data_o,
    input  logic                 dac_eoc_i
);

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    // A zero-width counter is not legal, so the disabled/1-cycle watchdog keeps one bit.
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic [WDW-1:0]  WD_LAST  = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [7:0]      GAP_LAST = 8'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [IW-1:0]   PTR_INIT = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    logic [2:0]      state_q,   state_d;
    logic [IW-1:0]   idx_q,     idx_d;
    logic [IW-1:0]   ptr_q,     ptr_d;
    logic [DW-1:0]   data_q,    data_d;
    logic [WDW-1:0]  wd_q,      wd_d;
    logic [7:0]      gap_q,     gap_d;
    logic [NREQ-1:0] gnt_q,     gnt_d;
    logic [NREQ-1:0] done_q,    done_d;
    logic            timeout_q, timeout_d;
    logic            busy_q,    busy_d;
    logic            start_q,   start_d;

    // First asserted request scanning ptr+1, ptr+2, ... wrapping at NREQ, so the
    // last owner has lowest priority on the next pick.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IW-1:0]   ptr);
        logic [IW-1:0] res;
        logic [IW-1:0] cand;
        logic          found;
        res   = ptr;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                res   = cand;
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

    // Next-state, counters and the registered output values for the coming cycle.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        data_d    = data_q;
        wd_d      = wd_q;
        gap_d     = gap_q;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    idx_d   = rr_pick(req_i, ptr_q);
                    data_d  = data_i[int'(idx_d)*DW +: DW];
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // eoc is checked first so a simultaneous expiry is not reported.
                if (dac_eoc_i) begin
                    state_d = S_DONE;
                end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_DONE: begin
                ptr_d   = idx_q;
                gap_d   = 8'd0;
                state_d = (GAP != 0) ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they leave flops aligned with it.
        start_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
        if ((state_d == S_START) || (state_d == S_WAIT) || (state_d == S_DONE)) begin
            gnt_d = ONE_HOT0 << idx_d;
        end else begin
            gnt_d = '0;
        end
        if (state_d == S_DONE) begin
            done_d = ONE_HOT0 << idx_d;
        end else begin
            done_d = '0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            ptr_q     <= PTR_INIT;
            data_q    <= '0;
            wd_q      <= '0;
            gap_q     <= 8'd0;
            gnt_q     <= '0;
            done_q    <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            data_q    <= data_d;
            wd_q      <= wd_d;
            gap_q     <= gap_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;
    assign busy_o      = busy_q;
    assign dac_start_o = start_q;
    assign dac_data_o  = data_q;

endmodule

// File: tb/tb_dac_share_arbiter.sv
// Self-checking bench for dac_share_arbiter (NREQ=4, DW=12, TIMEOUT=16, GAP=3).
// The bench plays the DAC driver and predicts each transaction from the
// round-robin rule, the requested eoc latency and the watchdog/gap limits.
module tb_dac_share_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 12;
    localparam int TIMEOUT = 16;
    localparam int GAP     = 3;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [NREQ-1:0]      req_i;
    logic [NREQ*DW-1:0]   data_i;
    logic [NREQ-1:0]      gnt_o;
    logic [NREQ-1:0]      done_o;
    logic                 timeout_o;
    logic                 busy_o;
    logic                 dac_start_o;
    logic [DW-1:0]        dac_data_o;
    logic                 dac_eoc_i;

    int errors = 0;
    int checks = 0;
    int ptr_m;

    dac_share_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .TIMEOUT (TIMEOUT),
        .GAP     (GAP)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .data_i      (data_i),
        .gnt_o       (gnt_o),
        .done_o      (done_o),
        .timeout_o   (timeout_o),
        .busy_o      (busy_o),
        .dac_start_o (dac_start_o),
        .dac_data_o  (dac_data_o),
        .dac_eoc_i   (dac_eoc_i)
    );

    // 10 ns clock.
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first set request after the last owner, wrapping.
    function automatic int pick_m(input logic [NREQ-1:0] r, input int p);
        for (int o = 1; o <= NREQ; o++) begin
            if (r[(p + o) % NREQ]) return (p + o) % NREQ;
        end
        return -1;
    endfunction

    task automatic scramble_data();
        for (int k = 0; k < NREQ; k++) data_i[k*DW +: DW] = DW'($urandom_range(0, 4095));
    endtask

    // One full transaction starting from an observed IDLE cycle with req_i set.
    // lat: WAIT cycle on which eoc is driven (0 or >TIMEOUT means never).
    task automatic txn(input int lat, input bit eoc_in_start, input bit drop,
                       input logic [NREQ-1:0] next_req);
        int              w;
        logic [DW-1:0]   code;
        logic [NREQ-1:0] oh;
        bit              exp_to;
        bit              seen;
        w = pick_m(req_i, ptr_m);
        if (w < 0) begin
            errors++;
            $display("FAIL txn_setup: observed req=%0h expected nonzero", req_i);
            return;
        end
        code   = data_i[w*DW +: DW];
        oh     = NREQ'(1) << w;
        exp_to = (lat < 1) || (lat > TIMEOUT);

        tick();  // START
        check("start_pulse", 32'(dac_start_o), 32'd1);
        check("start_gnt",   32'(gnt_o),       32'(oh));
        check("start_data",  32'(dac_data_o),  32'(code));
        check("start_busy",  32'(busy_o),      32'd1);
        check("start_done",  32'(done_o),      32'd0);
        scramble_data();
        if (drop) req_i[w] = 1'b0;
        dac_eoc_i = eoc_in_start;

        seen = 1'b0;
        for (int k = 1; k <= TIMEOUT && !seen; k++) begin
            tick();  // WAIT cycle k
            check("wait_start", 32'(dac_start_o), 32'd0);
            check("wait_gnt",   32'(gnt_o),       32'(oh));
            check("wait_data",  32'(dac_data_o),  32'(code));
            check("wait_done",  32'(done_o),      32'd0);
            check("wait_busy",  32'(busy_o),      32'd1);
            dac_eoc_i = (k == lat);
            seen      = (k == lat);
        end

        tick();  // DONE
        dac_eoc_i = 1'b0;
        check("done_pulse",   32'(done_o),      32'(oh));
        check("done_timeout", 32'(timeout_o),   32'(exp_to));
        check("done_gnt",     32'(gnt_o),       32'(oh));
        check("done_data",    32'(dac_data_o),  32'(code));
        check("done_start",   32'(dac_start_o), 32'd0);
        ptr_m = w;
        req_i = next_req;

        for (int h = 0; h < GAP; h++) begin
            dac_eoc_i = 1'($urandom_range(0, 1));
            tick();  // HOLD
            check("hold_gnt",     32'(gnt_o),       32'd0);
            check("hold_done",    32'(done_o),      32'd0);
            check("hold_timeout", 32'(timeout_o),   32'd0);
            check("hold_busy",    32'(busy_o),      32'd1);
            check("hold_start",   32'(dac_start_o), 32'd0);
        end
        dac_eoc_i = 1'b0;

        tick();  // IDLE
        check("idle_busy",  32'(busy_o),      32'd0);
        check("idle_gnt",   32'(gnt_o),       32'd0);
        check("idle_start", 32'(dac_start_o), 32'd0);
    endtask

    initial begin
        rst_ni    = 1'b0;
        req_i     = '0;
        data_i    = '0;
        dac_eoc_i = 1'b0;
        ptr_m     = NREQ - 1;

        // Reset state
        tick();
        tick();
        check("rst_gnt",   32'(gnt_o),       32'd0);
        check("rst_done",  32'(done_o),      32'd0);
        check("rst_to",    32'(timeout_o),   32'd0);
        check("rst_busy",  32'(busy_o),      32'd0);
        check("rst_start", 32'(dac_start_o), 32'd0);
        check("rst_data",  32'(dac_data_o),  32'd0);
        #2 rst_ni = 1'b1;

        // No requests: stays idle
        for (int i = 0; i < 3; i++) begin
            tick();
            check("noreq_busy",  32'(busy_o),      32'd0);
            check("noreq_start", 32'(dac_start_o), 32'd0);
        end

        // Single requester 0, code 0xABC, eoc 5 cycles after start
        scramble_data();
        data_i[0 +: DW] = 12'hABC;
        req_i = 4'b0001;
        txn(5, 1'b0, 1'b0, 4'b0000);

        // All four requesting, fixed latency: rotates through every requester
        req_i = 4'b1111;
        for (int i = 0; i < 5; i++) txn(3, 1'b0, 1'b0, 4'b1111);

        // After 1 completes, 1010 -> 3 then 1
        req_i = 4'b0010;
        txn(2, 1'b0, 1'b0, 4'b1010);
        txn(2, 1'b0, 1'b0, 4'b0010);
        txn(2, 1'b0, 1'b0, 4'b0000);

        // Watchdog: no eoc -> timeout; eoc on the last WAIT cycle -> no timeout
        req_i = 4'b0100;
        txn(0, 1'b0, 1'b0, 4'b0100);
        txn(TIMEOUT, 1'b0, 1'b0, 4'b0000);

        // eoc during START is ignored; requester drops req mid-transaction
        req_i = 4'b1000;
        txn(4, 1'b1, 1'b1, 4'b0000);

        // Randomized transactions
        req_i = NREQ'($urandom_range(1, 15));
        for (int i = 0; i < 24; i++) begin
            scramble_data();
            txn($urandom_range(0, TIMEOUT + 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), NREQ'($urandom_range(1, 15)));
        end

        // Reset during WAIT, then 1001 -> requester 0 first
        req_i = 4'b0100;
        tick();
        check("rst2_start", 32'(dac_start_o), 32'd1);
        tick();
        tick();
        #2 rst_ni = 1'b0;
        #1;
        check("arst_gnt",   32'(gnt_o),       32'd0);
        check("arst_busy",  32'(busy_o),      32'd0);
        check("arst_start", 32'(dac_start_o), 32'd0);
        check("arst_done",  32'(done_o),      32'd0);
        check("arst_to",    32'(timeout_o),   32'd0);
        check("arst_data",  32'(dac_data_o),  32'd0);
        tick();
        #2 rst_ni = 1'b1;
        ptr_m = NREQ - 1;
        req_i = 4'b1001;
        scramble_data();
        txn(3, 1'b0, 1'b0, 4'b1000);
        txn(3, 1'b0, 1'b0, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
